// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle sequencer for the 9-bit-instruction core.
// It owns the program counter and instruction register. It steps each
// instruction through fetch/execute/memory/multiply/writeback. It turns the
// decoder outputs into single-cycle enables for the register file, the data
// memory and the multiplier.
//
// Ports:
//   Clk, Reset_n       clock (rising edge), asynchronous active-low reset
//   Start              begin execution at PC 0 (only in IDLE or HALT)
//   Instr              ROM word at ProgCtr (combinational ROM)
//   Branch, MemtoReg,
//   MemWrite, RegWrite decoder outputs for IR
//   BranchCond         branch condition, sampled in EXEC
//   BranchTarget       branch target, sampled in EXEC
//   MemAck, MulDone    data memory completion / multiplier result ready
//   ProgCtr, IR        fetch address / latched instruction
//   RegWrEn            register file write strobe (one cycle, in WB)
//   MemReq             data memory request (held for the whole MEM state)
//   MulStart           multiplier start (first MUL cycle only)
//   Done, Err          halted / sticky wait-timeout flag
//   InstrCnt           retired-instruction count, saturating
//
// state | meaning
// IDLE  | after reset, waiting for Start
// FETCH | latch Instr into IR
// EXEC  | decode: halt, branch, or dispatch to MEM/MUL/WB
// MEM   | data memory access, waiting for MemAck
// MUL   | iterative multiply, waiting for MulDone
// WB    | register write strobe, PC+1, retire
// HALT  | Done; Start restarts from PC 0
module instr_sequencer #(
  parameter int PCW         = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [8:0]      Instr,
  input  logic            Branch,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic            BranchCond,
  input  logic [PCW-1:0]  BranchTarget,
  input  logic            MemAck,
  input  logic            MulDone,
  output logic [PCW-1:0]  ProgCtr,
  output logic [8:0]      IR,
  output logic            RegWrEn,
  output logic            MemReq,
  output logic            MulStart,
  output logic            Done,
  output logic            Err,
  output logic [CNTW-1:0] InstrCnt
);

  localparam int WTW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WTW-1:0] WAIT_LIM = WTW'(MEM_TIMEOUT - 1);
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_MUL  = 5'b11110;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_EXEC, ST_MEM, ST_MUL, ST_WB, ST_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [PCW-1:0]  pc_nxt;
  logic [8:0]      ir_nxt;
  logic            err_nxt;
  logic [CNTW-1:0] cnt_nxt;
  logic [WTW-1:0]  wait_cnt, wait_nxt;
  logic            regwr_nxt, mulst_nxt;
  logic            retire, run_clr;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      ProgCtr  <= '0;
      IR       <= '0;
      Err      <= 1'b0;
      InstrCnt <= '0;
      wait_cnt <= '0;
      RegWrEn  <= 1'b0;
      MulStart <= 1'b0;
    end else begin
      state    <= state_nxt;
      ProgCtr  <= pc_nxt;
      IR       <= ir_nxt;
      Err      <= err_nxt;
      InstrCnt <= cnt_nxt;
      wait_cnt <= wait_nxt;
      RegWrEn  <= regwr_nxt;
      MulStart <= mulst_nxt;
    end
  end

  // RegWrEn and MulStart are registered on the transition into WB/MUL.
  // This keeps every output a function of flops only.
  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    ir_nxt    = IR;
    err_nxt   = Err;
    wait_nxt  = wait_cnt;
    regwr_nxt = 1'b0;
    mulst_nxt = 1'b0;
    retire    = 1'b0;
    run_clr   = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = '0;
          err_nxt   = 1'b0;
          run_clr   = 1'b1;
        end
      end
      ST_FETCH: begin
        ir_nxt    = Instr;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (IR[8:4] == OP_HALT) begin
          state_nxt = ST_HALT;
          retire    = 1'b1;
        end else if (Branch) begin
          pc_nxt    = BranchCond ? BranchTarget : ProgCtr + PCW'(1);
          retire    = 1'b1;
          state_nxt = ST_FETCH;
        end else if (MemtoReg || MemWrite) begin
          state_nxt = ST_MEM;
          wait_nxt  = '0;
        end else if (IR[8:4] == OP_MUL) begin
          state_nxt = ST_MUL;
          wait_nxt  = '0;
          mulst_nxt = 1'b1;
        end else begin
          state_nxt = ST_WB;
          regwr_nxt = RegWrite;
        end
      end
      ST_MEM: begin
        if (MemAck) begin
          if (MemWrite) begin
            pc_nxt    = ProgCtr + PCW'(1);
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
            regwr_nxt = RegWrite;
          end
        end else if (wait_cnt == WAIT_LIM) begin
          err_nxt   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          wait_nxt = wait_cnt + WTW'(1);
        end
      end
      ST_MUL: begin
        if (MulDone) begin
          state_nxt = ST_WB;
          regwr_nxt = RegWrite;
        end else if (wait_cnt == WAIT_LIM) begin
          err_nxt   = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          wait_nxt = wait_cnt + WTW'(1);
        end
      end
      ST_WB: begin
        pc_nxt    = ProgCtr + PCW'(1);
        retire    = 1'b1;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase

    cnt_nxt = InstrCnt;
    if (run_clr)
      cnt_nxt = '0;
    else if (retire && (InstrCnt != '1))
      cnt_nxt = InstrCnt + CNTW'(1);
  end

  assign MemReq = (state == ST_MEM);
  assign Done   = (state == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  localparam logic [8:0] I_ADD  = 9'b00001_0000;
  localparam logic [8:0] I_BR   = 9'b10000_0000;
  localparam logic [8:0] I_LD   = 9'b01000_0000;
  localparam logic [8:0] I_ST   = 9'b01100_0000;
  localparam logic [8:0] I_MUL  = 9'b11110_0000;
  localparam logic [8:0] I_HALT = 9'b11111_0000;

  logic        Clk, Reset_n, Start;
  logic [8:0]  Instr;
  logic        Branch, MemtoReg, MemWrite, RegWrite;
  logic        BranchCond;
  logic [7:0]  BranchTarget;
  logic        MemAck, MulDone;
  logic [7:0]  ProgCtr;
  logic [8:0]  IR;
  logic        RegWrEn, MemReq, MulStart, Done, Err;
  logic [15:0] InstrCnt;

  logic [8:0]  rom [0:255];
  int checks = 0;
  int errors = 0;
  int ack_n    = 1;
  int mul_k    = 1;
  bit spur_mul = 0;

  int          d_cyc, memreq_c, mulst_c, regw_after;
  logic [63:0] regw_mask;

  instr_sequencer dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Instr(Instr),
    .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .BranchCond(BranchCond), .BranchTarget(BranchTarget),
    .MemAck(MemAck), .MulDone(MulDone),
    .ProgCtr(ProgCtr), .IR(IR), .RegWrEn(RegWrEn), .MemReq(MemReq),
    .MulStart(MulStart), .Done(Done), .Err(Err), .InstrCnt(InstrCnt)
  );

  // Environment: combinational ROM and a toy decoder for the opcodes above.
  assign Instr    = rom[ProgCtr];
  assign Branch   = (IR == I_BR);
  assign MemtoReg = (IR == I_LD);
  assign MemWrite = (IR == I_ST);
  assign RegWrite = (IR == I_ADD) || (IR == I_LD) || (IR == I_MUL);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fill_rom(input logic [8:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  // Pulse Start and run until Done, acting as memory and multiplier.
  // Cycle 1 is the first cycle after the edge that samples Start.
  task automatic run_prog(input int budget, output int done_cyc, output logic [63:0] regw_m,
                          output int memreq, output int mulst, output int regw_aft);
    int memrun, mulrun, done_at;
    bit mul_active;
    memrun = 0; mulrun = 0; done_at = -5; mul_active = 0;
    done_cyc = 0; regw_m = '0; memreq = 0; mulst = 0; regw_aft = 0;
    MemAck = 1'b0;
    MulDone = spur_mul;
    Start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      Start = 1'b0;
      if (RegWrEn) begin
        if (c < 64) regw_m[c] = 1'b1;
        if (done_at == c - 1) regw_aft++;
      end
      if (MemReq) memreq++;
      if (MulStart) mulst++;
      if (Done) begin
        done_cyc = c;
        break;
      end
      if (MemReq) begin
        memrun++;
        MemAck = (memrun == ack_n);
      end else begin
        memrun = 0;
        MemAck = 1'b0;
      end
      if (mul_active && MulDone) mul_active = 0;
      if (MulStart) begin
        mul_active = 1;
        mulrun = 1;
      end else if (mul_active) begin
        mulrun++;
      end
      if (mul_active) begin
        MulDone = (mulrun == mul_k);
        if (MulDone) done_at = c;
      end else begin
        MulDone = spur_mul;
      end
    end
    MemAck = 1'b0;
    MulDone = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ProgCtr !== 8'h00) begin errors++; $display("FAIL rst_pc got %0h exp 0", ProgCtr); end
    checks++; if (IR !== 9'h000) begin errors++; $display("FAIL rst_ir got %0h exp 0", IR); end
    checks++; if (RegWrEn !== 1'b0) begin errors++; $display("FAIL rst_regwren got %0b exp 0", RegWrEn); end
    checks++; if (MemReq !== 1'b0) begin errors++; $display("FAIL rst_memreq got %0b exp 0", MemReq); end
    checks++; if (MulStart !== 1'b0) begin errors++; $display("FAIL rst_mulstart got %0b exp 0", MulStart); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", Done); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", Err); end
    checks++; if (InstrCnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", InstrCnt); end
    tick();
    Reset_n = 1'b1;
    tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL idle_no_start_done got %0b exp 0", Done); end
  endtask

  task automatic test_alu();
    fill_rom(I_HALT);
    rom[0] = I_ADD; rom[1] = I_ADD;
    run_prog(60, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    // add: FETCH 1, EXEC 2, WB 3; add: 4-6; halt: FETCH 7, EXEC 8; HALT from 9.
    checks++; if (regw_mask !== 64'h48) begin errors++; $display("FAIL alu_regwren_cycles got %0h exp 48", regw_mask); end
    checks++; if (d_cyc !== 9) begin errors++; $display("FAIL alu_done_cycle got %0d exp 9", d_cyc); end
    checks++; if (InstrCnt !== 16'd3) begin errors++; $display("FAIL alu_cnt got %0d exp 3", InstrCnt); end
    checks++; if (ProgCtr !== 8'h02) begin errors++; $display("FAIL alu_pc got %0h exp 2", ProgCtr); end
    checks++; if (memreq_c !== 0) begin errors++; $display("FAIL alu_memreq got %0d exp 0", memreq_c); end
  endtask

  task automatic test_branch();
    fill_rom(I_HALT);
    for (int i = 0; i < 5; i++) rom[i] = I_ADD;
    rom[5] = I_BR;
    BranchTarget = 8'h20;
    BranchCond = 1'b1;
    run_prog(80, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    // 5 adds x3 + branch 2 + halt 2, Done on the following cycle.
    checks++; if (d_cyc !== 20) begin errors++; $display("FAIL br_taken_done got %0d exp 20", d_cyc); end
    checks++; if (ProgCtr !== 8'h20) begin errors++; $display("FAIL br_taken_pc got %0h exp 20", ProgCtr); end
    checks++; if (InstrCnt !== 16'd7) begin errors++; $display("FAIL br_taken_cnt got %0d exp 7", InstrCnt); end
    checks++; if ($countones(regw_mask) !== 5) begin errors++; $display("FAIL br_taken_regw got %0d exp 5", $countones(regw_mask)); end
    BranchCond = 1'b0;
    run_prog(80, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    checks++; if (ProgCtr !== 8'h06) begin errors++; $display("FAIL br_not_taken_pc got %0h exp 6", ProgCtr); end
    checks++; if (InstrCnt !== 16'd7) begin errors++; $display("FAIL br_not_taken_cnt got %0d exp 7", InstrCnt); end
    checks++; if ($countones(regw_mask) !== 5) begin errors++; $display("FAIL br_not_taken_regw got %0d exp 5", $countones(regw_mask)); end
  endtask

  task automatic test_mem();
    fill_rom(I_HALT);
    rom[0] = I_LD;
    ack_n = 3;
    run_prog(60, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    // load 3+3, halt 2 -> Done on cycle 9; WB in cycle 6.
    checks++; if (memreq_c !== 3) begin errors++; $display("FAIL ld_memreq got %0d exp 3", memreq_c); end
    checks++; if (regw_mask !== 64'h40) begin errors++; $display("FAIL ld_regwren got %0h exp 40", regw_mask); end
    checks++; if (d_cyc !== 9) begin errors++; $display("FAIL ld_done got %0d exp 9", d_cyc); end
    checks++; if (ProgCtr !== 8'h01) begin errors++; $display("FAIL ld_pc got %0h exp 1", ProgCtr); end
    rom[0] = I_ST;
    ack_n = 1;
    run_prog(60, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    checks++; if (memreq_c !== 1) begin errors++; $display("FAIL st_memreq got %0d exp 1", memreq_c); end
    checks++; if (regw_mask !== 64'h0) begin errors++; $display("FAIL st_regwren got %0h exp 0", regw_mask); end
    checks++; if (d_cyc !== 6) begin errors++; $display("FAIL st_done got %0d exp 6", d_cyc); end
    checks++; if (InstrCnt !== 16'd2) begin errors++; $display("FAIL st_cnt got %0d exp 2", InstrCnt); end
  endtask

  task automatic test_mul();
    fill_rom(I_HALT);
    rom[0] = I_MUL;
    mul_k = 4;
    spur_mul = 1;
    run_prog(60, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    spur_mul = 0;
    // MUL cycles 3-6, WB 7, halt 8-9, Done on cycle 10.
    checks++; if (mulst_c !== 1) begin errors++; $display("FAIL mul_start_cycles got %0d exp 1", mulst_c); end
    checks++; if (regw_mask !== 64'h80) begin errors++; $display("FAIL mul_regwren got %0h exp 80", regw_mask); end
    checks++; if (regw_after !== 1) begin errors++; $display("FAIL mul_regw_after_done got %0d exp 1", regw_after); end
    checks++; if (d_cyc !== 10) begin errors++; $display("FAIL mul_done got %0d exp 10", d_cyc); end
    checks++; if (ProgCtr !== 8'h01) begin errors++; $display("FAIL mul_pc got %0h exp 1", ProgCtr); end
  endtask

  task automatic test_timeout();
    fill_rom(I_HALT);
    rom[0] = I_LD;
    ack_n = 0;
    run_prog(80, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    checks++; if (memreq_c !== 15) begin errors++; $display("FAIL to_memreq got %0d exp 15", memreq_c); end
    checks++; if (d_cyc !== 18) begin errors++; $display("FAIL to_done got %0d exp 18", d_cyc); end
    checks++; if (Err !== 1'b1) begin errors++; $display("FAIL to_err got %0b exp 1", Err); end
    checks++; if (ProgCtr !== 8'h00) begin errors++; $display("FAIL to_pc got %0h exp 0", ProgCtr); end
    checks++; if (InstrCnt !== 16'd0) begin errors++; $display("FAIL to_cnt got %0d exp 0", InstrCnt); end
    checks++; if (regw_mask !== 64'h0) begin errors++; $display("FAIL to_regwren got %0h exp 0", regw_mask); end
    ack_n = 1;
    run_prog(60, d_cyc, regw_mask, memreq_c, mulst_c, regw_after);
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL to_restart_err got %0b exp 0", Err); end
    checks++; if (ProgCtr !== 8'h01) begin errors++; $display("FAIL to_restart_pc got %0h exp 1", ProgCtr); end
    checks++; if (InstrCnt !== 16'd2) begin errors++; $display("FAIL to_restart_cnt got %0d exp 2", InstrCnt); end
  endtask

  task automatic test_wrap();
    fill_rom(I_HALT);
    rom[0] = I_BR;
    rom[255] = I_ADD;
    BranchCond = 1'b1;
    BranchTarget = 8'hFF;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    checks++; if (ProgCtr !== 8'hFF) begin errors++; $display("FAIL wrap_fetch_ff got %0h exp ff", ProgCtr); end
    tick();
    tick();
    checks++; if (RegWrEn !== 1'b1) begin errors++; $display("FAIL wrap_regwren got %0b exp 1", RegWrEn); end
    tick();
    checks++; if (ProgCtr !== 8'h00) begin errors++; $display("FAIL wrap_pc got %0h exp 0", ProgCtr); end
    checks++; if (InstrCnt !== 16'd2) begin errors++; $display("FAIL wrap_cnt got %0d exp 2", InstrCnt); end
  endtask

  task automatic test_reset_mid_mul();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    fill_rom(I_HALT);
    rom[0] = I_MUL;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    checks++; if (MulStart !== 1'b1) begin errors++; $display("FAIL mid_mulstart got %0b exp 1", MulStart); end
    tick();
    Reset_n = 1'b0;
    Start = 1'b1;
    #1;
    checks++; if (IR !== 9'h000) begin errors++; $display("FAIL mid_rst_ir got %0h exp 0", IR); end
    checks++; if (ProgCtr !== 8'h00) begin errors++; $display("FAIL mid_rst_pc got %0h exp 0", ProgCtr); end
    checks++; if (MulStart !== 1'b0) begin errors++; $display("FAIL mid_rst_mulstart got %0b exp 0", MulStart); end
    checks++; if (RegWrEn !== 1'b0) begin errors++; $display("FAIL mid_rst_regwren got %0b exp 0", RegWrEn); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %0b exp 0", Done); end
    tick();
    checks++; if (IR !== 9'h000) begin errors++; $display("FAIL rst_beats_start_ir got %0h exp 0", IR); end
    Start = 1'b0;
    Reset_n = 1'b1;
    tick();
    tick();
    checks++; if (IR !== 9'h000) begin errors++; $display("FAIL post_rst_idle_ir got %0h exp 0", IR); end
    checks++; if (InstrCnt !== 16'd0) begin errors++; $display("FAIL post_rst_cnt got %0d exp 0", InstrCnt); end
  endtask

  initial begin
    Reset_n = 1'b0;
    Start = 1'b0;
    MemAck = 1'b0;
    MulDone = 1'b0;
    BranchCond = 1'b0;
    BranchTarget = 8'h00;
    fill_rom(I_HALT);
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_mul();
    test_timeout();
    test_wrap();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
